// File: rtl/exe_stage_unit.sv
// Execute stage: ALU with NZCV status register, branch target resolution,
// and the EXE/MEM pipeline register feeding the memory stage.
module exe_stage_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  wb_en_in,
  input  logic                  mem_r_in,
  input  logic                  mem_w_in,
  input  logic                  b_in,
  input  logic                  s_in,
  input  logic [3:0]            exe_cmd,
  input  logic [DATA_W-1:0]     val_rn,
  input  logic [DATA_W-1:0]     val2,
  input  logic [DATA_W-1:0]     val_rm,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [23:0]           imm24,
  input  logic [REG_ADDR_W-1:0] dest_in,
  output logic                  wb_en_out,
  output logic                  mem_r_out,
  output logic                  mem_w_out,
  output logic [DATA_W-1:0]     alu_res,
  output logic [DATA_W-1:0]     st_val,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic                  out_valid,
  output logic [3:0]            nzcv,
  output logic                  branch_taken,
  output logic [DATA_W-1:0]     branch_addr
);

  localparam int unsigned SUM_W = DATA_W + 1;
  localparam int unsigned MSB   = DATA_W - 1;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  logic [DATA_W-1:0] res;
  logic [DATA_W-1:0] add_b;
  logic              add_cin;
  logic              is_arith;
  logic              cmd_ok;
  logic [SUM_W-1:0]  sum;
  logic              flag_c;
  logic              flag_v;
  logic              nzcv_we;

  // Subtraction is rn + ~val2 + cin, so C naturally comes out as NOT borrow.
  always_comb begin
    res      = '0;
    add_b    = '0;
    add_cin  = 1'b0;
    is_arith = 1'b0;
    cmd_ok   = 1'b1;
    flag_c   = nzcv[1];
    flag_v   = nzcv[0];
    unique case (exe_cmd)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_AND: res = val_rn & val2;
      CMD_ORR: res = val_rn | val2;
      CMD_EOR: res = val_rn ^ val2;
      CMD_ADD: begin add_b = val2;  add_cin = 1'b0;    is_arith = 1'b1; end
      CMD_ADC: begin add_b = val2;  add_cin = nzcv[1]; is_arith = 1'b1; end
      CMD_SUB: begin add_b = ~val2; add_cin = 1'b1;    is_arith = 1'b1; end
      CMD_SBC: begin add_b = ~val2; add_cin = nzcv[1]; is_arith = 1'b1; end
      default: cmd_ok = 1'b0;
    endcase
    sum = {1'b0, val_rn} + {1'b0, add_b} + SUM_W'(add_cin);
    if (is_arith) begin
      res    = sum[MSB:0];
      flag_c = sum[DATA_W];
      flag_v = (val_rn[MSB] == add_b[MSB]) && (res[MSB] != val_rn[MSB]);
    end
  end

  assign nzcv_we = in_valid & s_in & ~freeze & ~flush & cmd_ok;

  // Status register
  always_ff @(posedge clk) begin
    if (rst) begin
      nzcv <= 4'b0000;
    end else if (nzcv_we) begin
      nzcv <= {res[MSB], (res == '0), flag_c, flag_v};
    end
  end

  // EXE/MEM pipeline register; a branch forwards a valid bubble
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wb_en_out <= 1'b0;
      mem_r_out <= 1'b0;
      mem_w_out <= 1'b0;
      out_valid <= 1'b0;
      alu_res   <= '0;
      st_val    <= '0;
      dest_out  <= '0;
    end else if (!freeze) begin
      wb_en_out <= in_valid & wb_en_in & ~b_in;
      mem_r_out <= in_valid & mem_r_in & ~b_in;
      mem_w_out <= in_valid & mem_w_in & ~b_in;
      out_valid <= in_valid;
      alu_res   <= res;
      st_val    <= val_rm;
      dest_out  <= dest_in;
    end
  end

  assign branch_taken = in_valid & b_in & ~freeze;
  assign branch_addr  = pc_in + DATA_W'($signed({imm24, 2'b00}));

endmodule

// File: tb/tb_exe_stage_unit.sv
// Bench for exe_stage_unit: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_exe_stage_unit;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, in_valid;
  logic        wb_en_in, mem_r_in, mem_w_in, b_in, s_in;
  logic [3:0]  exe_cmd;
  logic [31:0] val_rn, val2, val_rm, pc_in;
  logic [23:0] imm24;
  logic [3:0]  dest_in;
  logic        wb_en_out, mem_r_out, mem_w_out, out_valid, branch_taken;
  logic [31:0] alu_res, st_val, branch_addr;
  logic [3:0]  dest_out, nzcv;

  int checks = 0;
  int failures = 0;

  exe_stage_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid),
    .wb_en_in(wb_en_in), .mem_r_in(mem_r_in), .mem_w_in(mem_w_in), .b_in(b_in),
    .s_in(s_in), .exe_cmd(exe_cmd), .val_rn(val_rn), .val2(val2), .val_rm(val_rm),
    .pc_in(pc_in), .imm24(imm24), .dest_in(dest_in), .wb_en_out(wb_en_out),
    .mem_r_out(mem_r_out), .mem_w_out(mem_w_out), .alu_res(alu_res), .st_val(st_val),
    .dest_out(dest_out), .out_valid(out_valid), .nzcv(nzcv),
    .branch_taken(branch_taken), .branch_addr(branch_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU using wide signed/unsigned integer arithmetic
  function automatic void model_alu(input logic [3:0] cmd, input logic [31:0] rn,
                                    input logic [31:0] v2, input logic [3:0] f,
                                    output logic [31:0] r, output logic [3:0] nf,
                                    output bit ok);
    longint u, s;
    longint cin;
    ok = 1; r = 0; nf = f;
    case (cmd)
      4'd1: r = v2;
      4'd9: r = ~v2;
      4'd6: r = rn & v2;
      4'd7: r = rn | v2;
      4'd8: r = rn ^ v2;
      4'd2, 4'd3: begin
        cin = (cmd == 4'd3) ? longint'(f[1]) : 0;
        u = longint'(rn) + longint'(v2) + cin;
        s = longint'($signed(rn)) + longint'($signed(v2)) + cin;
        r = u[31:0];
        nf[1] = (u > 64'sd4294967295);
        nf[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd4, 4'd5: begin
        cin = (cmd == 4'd5) ? longint'(!f[1]) : 0;
        u = longint'(rn) - longint'(v2) - cin;
        s = longint'($signed(rn)) - longint'($signed(v2)) - cin;
        r = u[31:0];
        nf[1] = (longint'(rn) >= longint'(v2) + cin);
        nf[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      default: ok = 0;
    endcase
    if (ok) begin
      nf[3] = r[31];
      nf[2] = (r == 0);
    end
  endfunction

  logic        m_wb, m_mr, m_mw, m_ov;
  logic [31:0] m_res, m_st;
  logic [3:0]  m_dest, m_nzcv;
  bit          m_ready = 0;

  always @(posedge clk) begin
    logic [31:0] r;
    logic [3:0]  nf;
    bit          ok;
    model_alu(exe_cmd, val_rn, val2, m_nzcv, r, nf, ok);
    if (rst) begin
      {m_wb, m_mr, m_mw, m_ov} = 4'b0;
      m_res = 0; m_st = 0; m_dest = 0; m_nzcv = 0;
    end else if (flush) begin
      {m_wb, m_mr, m_mw, m_ov} = 4'b0;
      m_res = 0; m_st = 0; m_dest = 0;
    end else if (!freeze) begin
      m_wb = in_valid && wb_en_in && !b_in;
      m_mr = in_valid && mem_r_in && !b_in;
      m_mw = in_valid && mem_w_in && !b_in;
      m_ov = in_valid;
      m_res = r; m_st = val_rm; m_dest = dest_in;
      if (in_valid && s_in && ok) m_nzcv = nf;
    end
    m_ready = 1;
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("wb_en_out", 64'(wb_en_out), 64'(m_wb));
      chk("mem_r_out", 64'(mem_r_out), 64'(m_mr));
      chk("mem_w_out", 64'(mem_w_out), 64'(m_mw));
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("alu_res", 64'(alu_res), 64'(m_res));
      chk("st_val", 64'(st_val), 64'(m_st));
      chk("dest_out", 64'(dest_out), 64'(m_dest));
      chk("nzcv", 64'(nzcv), 64'(m_nzcv));
      chk("branch_taken", 64'(branch_taken), 64'(in_valid && b_in && !freeze));
      chk("branch_addr", 64'(branch_addr),
          64'(32'(longint'(pc_in) + longint'($signed(imm24)) * 4)));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic op(input logic iv, input logic [3:0] cmd, input logic s,
                    input logic [31:0] rn, input logic [31:0] v2);
    in_valid = iv; exe_cmd = cmd; s_in = s; val_rn = rn; val2 = v2;
    wb_en_in = 1'b1; mem_r_in = 1'b0; mem_w_in = 1'b0; b_in = 1'b0;
    val_rm = 32'h0; dest_in = 4'h3;
  endtask

  initial begin
    rst = 1; freeze = 0; flush = 0; in_valid = 0;
    wb_en_in = 0; mem_r_in = 0; mem_w_in = 0; b_in = 0; s_in = 0;
    exe_cmd = 0; val_rn = 0; val2 = 0; val_rm = 0; pc_in = 0; imm24 = 0; dest_in = 0;
    step(2);
    rst = 0;
    step(1);
    chk("reset_alu_res", 64'(alu_res), 64'h0);
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    chk("reset_nzcv", 64'(nzcv), 64'h0);

    op(1, 4'b0010, 1, 32'h7FFF_FFFF, 32'h1); step(1);
    chk("add_ovf_res", 64'(alu_res), 64'h8000_0000);
    chk("add_ovf_nzcv", 64'(nzcv), 64'h9);
    op(1, 4'b0100, 1, 32'd5, 32'd5); step(1);
    chk("sub_zero_res", 64'(alu_res), 64'h0);
    chk("sub_zero_nzcv", 64'(nzcv), 64'h6);
    op(1, 4'b0011, 0, 32'd1, 32'd1); step(1);
    chk("adc_res", 64'(alu_res), 64'h3);
    chk("adc_nzcv_hold", 64'(nzcv), 64'h6);
    op(1, 4'b0010, 1, 32'd1, 32'd1); step(1);
    chk("add_clear_c", 64'(nzcv), 64'h0);
    op(1, 4'b0101, 1, 32'd5, 32'd2); step(1);
    chk("sbc_res", 64'(alu_res), 64'h2);
    chk("sbc_nzcv", 64'(nzcv), 64'h2);

    // logical ops keep C/V
    op(1, 4'b0110, 1, 32'hF0F0_F0F0, 32'hFF00_FF00); step(1);
    op(1, 4'b0111, 1, 32'h1, 32'h8000_0000); step(1);
    op(1, 4'b1000, 1, 32'hAAAA_AAAA, 32'hAAAA_AAAA); step(1);
    op(1, 4'b1001, 1, 32'h0, 32'h0); step(1);
    op(1, 4'b0001, 1, 32'h0, 32'h1234_5678); step(1);
    op(1, 4'b0100, 1, 32'h8000_0000, 32'h1); step(1);
    op(1, 4'b0000, 1, 32'h1, 32'h1); step(1);
    chk("bad_cmd_res", 64'(alu_res), 64'h0);

    op(1, 4'b0010, 0, 32'h100, 32'h8);
    wb_en_in = 0; mem_w_in = 1; val_rm = 32'hAB; dest_in = 4'h7; step(1);
    chk("str_mem_w", 64'(mem_w_out), 64'h1);
    chk("str_addr", 64'(alu_res), 64'h108);
    chk("str_data", 64'(st_val), 64'hAB);
    chk("str_wb", 64'(wb_en_out), 64'h0);
    op(1, 4'b0010, 0, 32'h200, 32'h4); mem_r_in = 1; step(1);
    op(0, 4'b0010, 1, 32'h1, 32'h1); mem_r_in = 1; step(1);
    chk("invalid_wb", 64'(wb_en_out), 64'h0);

    op(1, 4'b0000, 0, 32'h0, 32'h0); b_in = 1; pc_in = 32'h20; imm24 = 24'hFFFFFE; #1;
    chk("br_taken", 64'(branch_taken), 64'h1);
    chk("br_addr", 64'(branch_addr), 64'h18);
    freeze = 1; #1;
    chk("br_frozen", 64'(branch_taken), 64'h0);
    step(1);
    freeze = 0; step(1);
    chk("br_bubble_valid", 64'(out_valid), 64'h1);
    chk("br_bubble_wb", 64'(wb_en_out), 64'h0);
    pc_in = 32'hFFFF_FFFC; imm24 = 24'h000001; #1;
    chk("br_wrap", 64'(branch_addr), 64'h0);

    op(1, 4'b0100, 1, 32'd3, 32'd7); step(1);
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      op(1, 4'b0010, 1, 32'(i), 32'hFFFF_FFFF); dest_in = 4'(i); step(1);
    end
    chk("freeze_res", 64'(alu_res), 64'hFFFF_FFFC);
    chk("freeze_nzcv", 64'(nzcv), 64'h8);
    flush = 1; step(1);
    chk("flush_freeze_valid", 64'(out_valid), 64'h0);
    chk("flush_freeze_res", 64'(alu_res), 64'h0);
    freeze = 0; op(1, 4'b0100, 1, 32'd0, 32'd0); step(1);
    chk("flush_nzcv_hold", 64'(nzcv), 64'h8);
    flush = 0; step(1);

    rst = 1; step(1);
    chk("midrst_nzcv", 64'(nzcv), 64'h0);
    chk("midrst_valid", 64'(out_valid), 64'h0);
    rst = 0; in_valid = 0; step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
